// File: rtl/hwag_sync_gen.sv
// hwag_sync_gen - crank angle generator for missing-tooth wheels (60-2, 36-1, ...).
//
// Timestamps filtered tooth edges, finds the missing-tooth gap, tracks the tooth
// index and interpolates a fine angle between edges. Tooth and gap counts are
// run-time configuration; widths and the subdivision range are parameters.
//
// State table:
//   S_SEARCH | no angle reference; waiting for a gap with 3 valid captures
//   S_SYNC   | locked; tooth/angle valid, every edge is checked against the wheel
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   ena               0 clears all state (cfg inputs are external)
//   edge_in           one-cycle pulse per filtered tooth edge
//   cfg_teeth/gap     tooth slots per revolution (missing included) / missing teeth
//   cfg_shift         log2 angle ticks per tooth slot
//   cfg_min/max       legal normal-tooth period window
//   period            last captured edge-to-edge period
//   tooth, angle      tooth index (0 = first edge after gap), interpolated angle
//   sync, cycle_phase locked flag, 720-degree half-cycle bit
//   evt_*             one-cycle registered event pulses
module hwag_sync_gen #(
  parameter int PW  = 24,
  parameter int TW  = 8,
  parameter int AW  = 24,
  parameter int SHW = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           ena,
  input  logic           edge_in,
  input  logic [TW-1:0]  cfg_teeth,
  input  logic [TW-1:0]  cfg_gap,
  input  logic [SHW-1:0] cfg_shift,
  input  logic [PW-1:0]  cfg_min,
  input  logic [PW-1:0]  cfg_max,
  output logic [PW-1:0]  period,
  output logic [TW-1:0]  tooth,
  output logic [AW-1:0]  angle,
  output logic           sync,
  output logic           cycle_phase,
  output logic           evt_tooth,
  output logic           evt_gap,
  output logic           evt_lost,
  output logic           evt_ovf
);

  typedef enum logic {S_SEARCH, S_SYNC} state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] cnt_q, cnt_d;
  logic [PW-1:0] cap0_q, cap0_d, cap1_q, cap1_d, cap2_q, cap2_d;
  logic [1:0]    vcnt_q, vcnt_d;
  logic [PW-1:0] period_q, period_d;
  logic [TW-1:0] tooth_q, tooth_d;
  logic [AW-1:0] angle_q, angle_d;
  logic [PW-1:0] tick_top_q, tick_top_d;
  logic [PW-1:0] tick_q, tick_d;
  logic          phase_q, phase_d;
  logic          ev_tooth_q, ev_tooth_d, ev_gap_q, ev_gap_d;
  logic          ev_lost_q, ev_lost_d, ev_ovf_q, ev_ovf_d;

  logic          started, sat, lose;
  logic [PW:0]   thr1;
  logic          g_hi, g_c2, c0_ok, c1_ok, gap_ok, norm_ok;
  logic [1:0]    vcnt_n;
  logic [TW-1:0] last_norm, tooth_new;
  logic          is_gap_slot;
  logic [AW-1:0] next_edge, angle_inc;
  logic [PW-1:0] tt_norm, tt_gap;

  // Interpolation step in clk cycles; never 0 so the tick counter always advances.
  function automatic logic [PW-1:0] tick_top_f(input logic [PW-1:0] base,
                                               input logic [SHW-1:0] sh);
    logic [PW-1:0] t;
    t = base >> sh;
    return (t == '0) ? PW'(1) : t;
  endfunction

  always_comb begin
    // cnt_q == 0 means no edge seen since reset/overflow: counter idle, no capture.
    started   = (cnt_q != '0);
    sat       = (cnt_q == '1);

    // Criteria are evaluated on the history as it will look after this edge.
    thr1      = {1'b0, cap0_q} + {2'b00, cap0_q[PW-1:1]};
    g_hi      = {1'b0, cnt_q} >= thr1;
    g_c2      = {1'b0, cap1_q} < thr1;
    c1_ok     = (cap0_q >= cfg_min) && (cap0_q <= cfg_max);
    c0_ok     = (cnt_q >= cfg_min) && (cnt_q <= cfg_max);
    gap_ok    = g_hi && g_c2 && c1_ok;
    norm_ok   = !g_hi && c0_ok;
    vcnt_n    = (vcnt_q == 2'd3) ? 2'd3 : vcnt_q + 2'd1;

    last_norm   = cfg_teeth - cfg_gap - TW'(1);
    is_gap_slot = (tooth_q == last_norm);
    tooth_new   = tooth_q + TW'(1);
    next_edge   = is_gap_slot ? (AW'(cfg_teeth) << cfg_shift)
                              : (AW'(tooth_new) << cfg_shift);
    angle_inc   = angle_q + AW'(1);
    tt_norm     = tick_top_f(cnt_q, cfg_shift);
    // Gap edges interpolate from the last normal period, not the long gap period.
    tt_gap      = tick_top_f(cap0_q, cfg_shift);

    state_d    = state_q;
    cnt_d      = started ? cnt_q + PW'(1) : '0;
    cap0_d     = cap0_q;
    cap1_d     = cap1_q;
    cap2_d     = cap2_q;
    vcnt_d     = vcnt_q;
    period_d   = period_q;
    tooth_d    = tooth_q;
    angle_d    = angle_q;
    tick_top_d = tick_top_q;
    tick_d     = tick_q;
    phase_d    = phase_q;
    ev_tooth_d = 1'b0;
    ev_gap_d   = 1'b0;
    ev_lost_d  = 1'b0;
    ev_ovf_d   = 1'b0;
    lose       = 1'b0;

    if (sat) begin
      // Overflow beats a coincident edge; counter goes idle until the next edge.
      cnt_d    = '0;
      cap0_d   = '0;
      cap1_d   = '0;
      cap2_d   = '0;
      vcnt_d   = '0;
      ev_ovf_d = 1'b1;
      lose     = (state_q == S_SYNC);
    end else if (edge_in) begin
      cnt_d = PW'(1);
      if (started) begin
        cap0_d   = cnt_q;
        cap1_d   = cap0_q;
        cap2_d   = cap1_q;
        vcnt_d   = vcnt_n;
        period_d = cnt_q;
        case (state_q)
          S_SEARCH: begin
            if (vcnt_n == 2'd3 && gap_ok) begin
              state_d    = S_SYNC;
              tooth_d    = '0;
              angle_d    = '0;
              ev_gap_d   = 1'b1;
              tick_top_d = tt_gap;
              tick_d     = tt_gap - PW'(1);
            end
          end
          S_SYNC: begin
            if (is_gap_slot) begin
              if (gap_ok) begin
                tooth_d    = '0;
                angle_d    = '0;
                phase_d    = !phase_q;
                ev_gap_d   = 1'b1;
                tick_top_d = tt_gap;
                tick_d     = tt_gap - PW'(1);
              end else begin
                lose = 1'b1;
              end
            end else begin
              if (norm_ok) begin
                tooth_d    = tooth_new;
                angle_d    = AW'(tooth_new) << cfg_shift;
                ev_tooth_d = 1'b1;
                tick_top_d = tt_norm;
                tick_d     = tt_norm - PW'(1);
              end else begin
                lose = 1'b1;
              end
            end
          end
          default: state_d = S_SEARCH;
        endcase
      end
    end else if (state_q == S_SYNC) begin
      // Tick down-counter; angle stops one short of the next edge's angle.
      if (tick_q == '0) begin
        tick_d = tick_top_q - PW'(1);
        if (angle_inc < next_edge) angle_d = angle_inc;
      end else begin
        tick_d = tick_q - PW'(1);
      end
    end

    if (lose) begin
      state_d   = S_SEARCH;
      tooth_d   = '0;
      angle_d   = '0;
      tick_d    = '0;
      ev_lost_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || !ena) begin
      state_q    <= S_SEARCH;
      cnt_q      <= '0;
      cap0_q     <= '0;
      cap1_q     <= '0;
      cap2_q     <= '0;
      vcnt_q     <= '0;
      period_q   <= '0;
      tooth_q    <= '0;
      angle_q    <= '0;
      tick_top_q <= '0;
      tick_q     <= '0;
      phase_q    <= 1'b0;
      ev_tooth_q <= 1'b0;
      ev_gap_q   <= 1'b0;
      ev_lost_q  <= 1'b0;
      ev_ovf_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      cap0_q     <= cap0_d;
      cap1_q     <= cap1_d;
      cap2_q     <= cap2_d;
      vcnt_q     <= vcnt_d;
      period_q   <= period_d;
      tooth_q    <= tooth_d;
      angle_q    <= angle_d;
      tick_top_q <= tick_top_d;
      tick_q     <= tick_d;
      phase_q    <= phase_d;
      ev_tooth_q <= ev_tooth_d;
      ev_gap_q   <= ev_gap_d;
      ev_lost_q  <= ev_lost_d;
      ev_ovf_q   <= ev_ovf_d;
    end
  end

  assign period      = period_q;
  assign tooth       = tooth_q;
  assign angle       = angle_q;
  assign sync        = (state_q == S_SYNC);
  assign cycle_phase = phase_q;
  assign evt_tooth   = ev_tooth_q;
  assign evt_gap     = ev_gap_q;
  assign evt_lost    = ev_lost_q;
  assign evt_ovf     = ev_ovf_q;

endmodule

// File: tb/tb_hwag_sync_gen.sv
// tb_hwag_sync_gen - scenario bench for hwag_sync_gen (PW=12 build).
// Each edge pushes its expected outputs to a scoreboard; the record is popped and
// compared right after the DUT registers the edge. Between edges the angle is
// checked against the expected interpolation staircase.
module tb_hwag_sync_gen;

  localparam int PW = 12, TW = 8, AW = 24, SHW = 4;
  localparam logic [3:0] EV_N = 4'b0000, EV_T = 4'b1000, EV_G = 4'b0100,
                         EV_L = 4'b0010, EV_O = 4'b0001;

  logic           clk = 1'b0;
  logic           rst, ena, edge_in;
  logic [TW-1:0]  cfg_teeth, cfg_gap;
  logic [SHW-1:0] cfg_shift;
  logic [PW-1:0]  cfg_min, cfg_max;
  logic [PW-1:0]  period;
  logic [TW-1:0]  tooth;
  logic [AW-1:0]  angle;
  logic           sync, cycle_phase, evt_tooth, evt_gap, evt_lost, evt_ovf;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic          sync;
    logic [TW-1:0] tooth;
    logic [AW-1:0] angle;
    logic [3:0]    evt;
    logic [PW-1:0] period;
    logic          chkp;
  } exp_t;

  exp_t sb[$];

  hwag_sync_gen #(.PW(PW), .TW(TW), .AW(AW), .SHW(SHW)) dut (
    .clk(clk), .rst(rst), .ena(ena), .edge_in(edge_in),
    .cfg_teeth(cfg_teeth), .cfg_gap(cfg_gap), .cfg_shift(cfg_shift),
    .cfg_min(cfg_min), .cfg_max(cfg_max),
    .period(period), .tooth(tooth), .angle(angle), .sync(sync),
    .cycle_phase(cycle_phase), .evt_tooth(evt_tooth), .evt_gap(evt_gap),
    .evt_lost(evt_lost), .evt_ovf(evt_ovf)
  );

  always #5 clk = ~clk;

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic exp_t mk(input logic s, input int t, input int a,
                              input logic [3:0] ev, input int p, input logic cp);
    exp_t e;
    e.sync = s; e.tooth = t[TW-1:0]; e.angle = a[AW-1:0];
    e.evt = ev; e.period = p[PW-1:0]; e.chkp = cp;
    return e;
  endfunction

  // Edge p cycles after the previous one. While waiting, angle must follow
  // min(ib + j/itt, ilim) and no event may fire.
  task automatic send_edge(input int p, input exp_t e, input int ib, input int itt,
                           input int ilim);
    exp_t g;
    int   ea;
    sb.push_back(e);
    edge_in = 1'b0;
    for (int j = 1; j < p; j++) begin
      cyc();
      ea = ib + j / itt;
      if (ea > ilim) ea = ilim;
      n_checks++;
      if (angle !== AW'(ea)) begin
        n_errors++;
        $display("FAIL interp_angle: j=%0d got %0d expected %0d", j, angle, ea);
      end
      n_checks++;
      if ({evt_tooth, evt_gap, evt_lost, evt_ovf} !== EV_N) begin
        n_errors++;
        $display("FAIL idle_evt: j=%0d got %b expected %b", j,
                 {evt_tooth, evt_gap, evt_lost, evt_ovf}, EV_N);
      end
    end
    edge_in = 1'b1;
    cyc();
    edge_in = 1'b0;
    g = sb.pop_front();
    n_checks++;
    if (sync !== g.sync) begin
      n_errors++; $display("FAIL edge_sync: got %b expected %b", sync, g.sync);
    end
    n_checks++;
    if (tooth !== g.tooth) begin
      n_errors++; $display("FAIL edge_tooth: got %0d expected %0d", tooth, g.tooth);
    end
    n_checks++;
    if (angle !== g.angle) begin
      n_errors++; $display("FAIL edge_angle: got %0d expected %0d", angle, g.angle);
    end
    n_checks++;
    if ({evt_tooth, evt_gap, evt_lost, evt_ovf} !== g.evt) begin
      n_errors++;
      $display("FAIL edge_evt: got %b expected %b", {evt_tooth, evt_gap, evt_lost, evt_ovf}, g.evt);
    end
    if (g.chkp) begin
      n_checks++;
      if (period !== g.period) begin
        n_errors++; $display("FAIL edge_period: got %0d expected %0d", period, g.period);
      end
    end
  endtask

  task automatic apply_reset(input int teeth, input int gap, input int sh,
                             input int mn, input int mx);
    cfg_teeth = TW'(teeth); cfg_gap = TW'(gap); cfg_shift = SHW'(sh);
    cfg_min = PW'(mn); cfg_max = PW'(mx);
    ena = 1'b1; edge_in = 1'b0; rst = 1'b1;
    repeat (3) cyc();
    rst = 1'b0;
  endtask

  // 60-2 wheel at 100 cycles/tooth: start edge, 57 normal captures, then the gap.
  task automatic do_sync_60_2();
    send_edge(20, mk(0, 0, 0, EV_N, 0, 1'b0), 0, 1, 0);
    for (int k = 0; k < 57; k++) send_edge(100, mk(0, 0, 0, EV_N, 100, 1'b1), 0, 1, 0);
    send_edge(300, mk(1, 0, 0, EV_G, 300, 1'b1), 0, 1, 0);
  endtask

  task automatic test_reset();
    cfg_teeth = 8'd60; cfg_gap = 8'd2; cfg_shift = 4'd2;
    cfg_min = 12'd50; cfg_max = 12'd200;
    ena = 1'b1; edge_in = 1'b0; rst = 1'b1;
    repeat (3) cyc();
    n_checks++;
    if ({sync, cycle_phase, evt_tooth, evt_gap, evt_lost, evt_ovf} !== 6'b0) begin
      n_errors++; $display("FAIL reset_flags: got %b expected 000000",
                           {sync, cycle_phase, evt_tooth, evt_gap, evt_lost, evt_ovf});
    end
    n_checks++;
    if (tooth !== '0 || angle !== '0 || period !== '0) begin
      n_errors++; $display("FAIL reset_values: got tooth=%0d angle=%0d period=%0d expected 0",
                           tooth, angle, period);
    end
    rst = 1'b0;
  endtask

  task automatic test_sync_60_2();
    logic ph;
    apply_reset(60, 2, 2, 50, 200);
    do_sync_60_2();
    for (int k = 1; k <= 57; k++)
      send_edge(100, mk(1, k, 4 * k, EV_T, 100, 1'b1), 4 * (k - 1), 25, 4 * k - 1);
    ph = cycle_phase;
    send_edge(300, mk(1, 0, 0, EV_G, 300, 1'b1), 228, 25, 239);
    n_checks++;
    if (cycle_phase !== ~ph) begin
      n_errors++; $display("FAIL phase_toggle: got %b expected %b", cycle_phase, ~ph);
    end
    send_edge(100, mk(1, 1, 4, EV_T, 100, 1'b1), 0, 25, 3);
  endtask

  task automatic test_slow();
    apply_reset(60, 2, 2, 50, 1000);
    do_sync_60_2();
    send_edge(100, mk(1, 1, 4, EV_T, 100, 1'b1), 0, 25, 3);
    send_edge(140, mk(1, 2, 8, EV_T, 140, 1'b1), 4, 25, 7);
    send_edge(196, mk(1, 3, 12, EV_T, 196, 1'b1), 8, 35, 11);
    send_edge(270, mk(1, 4, 16, EV_T, 270, 1'b1), 12, 49, 15);
    send_edge(400, mk(1, 5, 20, EV_T, 400, 1'b1), 16, 67, 19);
  endtask

  task automatic test_loss();
    apply_reset(60, 2, 2, 50, 200);
    do_sync_60_2();
    for (int k = 1; k <= 19; k++)
      send_edge(100, mk(1, k, 4 * k, EV_T, 100, 1'b1), 4 * (k - 1), 25, 4 * k - 1);
    send_edge(300, mk(0, 0, 0, EV_L, 300, 1'b1), 76, 25, 79);
    for (int k = 0; k < 38; k++) send_edge(100, mk(0, 0, 0, EV_N, 100, 1'b1), 0, 1, 0);
    send_edge(300, mk(1, 0, 0, EV_G, 300, 1'b1), 0, 1, 0);
    send_edge(100, mk(1, 1, 4, EV_T, 100, 1'b1), 0, 25, 3);
  endtask

  task automatic test_ovf();
    int at, extra;
    apply_reset(60, 2, 2, 50, 200);
    do_sync_60_2();
    for (int k = 1; k <= 3; k++)
      send_edge(100, mk(1, k, 4 * k, EV_T, 100, 1'b1), 4 * (k - 1), 25, 4 * k - 1);
    at = -1;
    for (int j = 1; j <= 5000 && at < 0; j++) begin
      cyc();
      if (evt_ovf === 1'b1) begin
        at = j;
        n_checks++;
        if (evt_lost !== 1'b1 || sync !== 1'b0) begin
          n_errors++; $display("FAIL ovf_lost: got evt_lost=%b sync=%b expected 1 0", evt_lost, sync);
        end
        n_checks++;
        if (tooth !== '0 || angle !== '0) begin
          n_errors++; $display("FAIL ovf_clear: got tooth=%0d angle=%0d expected 0", tooth, angle);
        end
      end
    end
    n_checks++;
    if (at < 4094 || at > 4096) begin
      n_errors++; $display("FAIL ovf_time: got cycle %0d expected 4095", at);
    end
    extra = 0;
    for (int j = 0; j < 300; j++) begin
      cyc();
      if (evt_ovf === 1'b1) extra++;
    end
    n_checks++;
    if (extra != 0) begin
      n_errors++; $display("FAIL ovf_single: got %0d extra pulses expected 0", extra);
    end
    send_edge(50, mk(0, 0, 0, EV_N, 0, 1'b0), 0, 1, 0);
    send_edge(100, mk(0, 0, 0, EV_N, 100, 1'b1), 0, 1, 0);
    send_edge(300, mk(0, 0, 0, EV_N, 300, 1'b1), 0, 1, 0);
    send_edge(100, mk(0, 0, 0, EV_N, 100, 1'b1), 0, 1, 0);
    send_edge(100, mk(0, 0, 0, EV_N, 100, 1'b1), 0, 1, 0);
    send_edge(300, mk(1, 0, 0, EV_G, 300, 1'b1), 0, 1, 0);
  endtask

  task automatic test_36_1_reset();
    apply_reset(36, 1, 3, 50, 200);
    send_edge(500, mk(0, 0, 0, EV_N, 0, 1'b0), 0, 1, 0);
    for (int k = 0; k < 10; k++) send_edge(100, mk(0, 0, 0, EV_N, 100, 1'b1), 0, 1, 0);
    send_edge(200, mk(1, 0, 0, EV_G, 200, 1'b1), 0, 1, 0);
    for (int k = 1; k <= 5; k++)
      send_edge(100, mk(1, k, 8 * k, EV_T, 100, 1'b1), 8 * (k - 1), 12, 8 * k - 1);
    repeat (40) cyc();
    rst = 1'b1;
    cyc();
    n_checks++;
    if ({sync, cycle_phase, evt_tooth, evt_gap, evt_lost, evt_ovf} !== 6'b0) begin
      n_errors++; $display("FAIL midrev_rst_flags: got %b expected 000000",
                           {sync, cycle_phase, evt_tooth, evt_gap, evt_lost, evt_ovf});
    end
    n_checks++;
    if (tooth !== '0 || angle !== '0 || period !== '0) begin
      n_errors++; $display("FAIL midrev_rst_values: got tooth=%0d angle=%0d period=%0d expected 0",
                           tooth, angle, period);
    end
    rst = 1'b0;
    send_edge(500, mk(0, 0, 0, EV_N, 0, 1'b0), 0, 1, 0);
    send_edge(100, mk(0, 0, 0, EV_N, 100, 1'b1), 0, 1, 0);
    send_edge(200, mk(0, 0, 0, EV_N, 200, 1'b1), 0, 1, 0);
    send_edge(100, mk(0, 0, 0, EV_N, 100, 1'b1), 0, 1, 0);
    send_edge(100, mk(0, 0, 0, EV_N, 100, 1'b1), 0, 1, 0);
    send_edge(200, mk(1, 0, 0, EV_G, 200, 1'b1), 0, 1, 0);
    send_edge(100, mk(1, 1, 8, EV_T, 100, 1'b1), 0, 12, 7);
    ena = 1'b0;
    cyc();
    n_checks++;
    if (sync !== 1'b0 || tooth !== '0 || angle !== '0) begin
      n_errors++; $display("FAIL ena_clear: got sync=%b tooth=%0d angle=%0d expected 0",
                           sync, tooth, angle);
    end
    ena = 1'b1;
  endtask

  initial begin
    rst = 1'b1; ena = 1'b1; edge_in = 1'b0;
    test_reset();
    test_sync_60_2();
    test_slow();
    test_loss();
    test_ovf();
    test_36_1_reset();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
